// File: rtl/ss_adc_conv_ctrl_pkg.sv
// Shared types for the single-slope column ADC: controller FSM states, pipeline latency
// and the capture-code type used by the register array and readout.
package ss_adc_pkg;

  localparam int LAT             = 3;
  localparam int COUNT_WIDTH_DEF = 8;

  typedef logic [COUNT_WIDTH_DEF-1:0] count_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RAMP,
    DRAIN,
    FINISH
  } state_e;

endpackage

// File: rtl/ss_adc_conv_ctrl_if.sv
// Signal bundle between the conversion controller and its surroundings (sequencer,
// comparators, ramp DAC and pixel capture register array).
interface ss_adc_conv_ctrl_if import ss_adc_pkg::*; #(
  parameter int NUM_PIXELS  = 5,
  parameter int COUNT_WIDTH = 8
);

  // Handshake: start is a level request with no ready; it is taken only when the controller
  // is idle (busy=0) and ignored otherwise. enable/count form a one-cycle push into the
  // register array with no back-pressure; done pulses once when a conversion completes.
  logic                   start;
  logic [NUM_PIXELS-1:0]  comp_in;
  logic                   ramp_reset;
  logic [COUNT_WIDTH-1:0] ramp_code;
  logic [COUNT_WIDTH-1:0] count;
  logic [NUM_PIXELS-1:0]  enable;
  logic                   busy;
  logic                   done;
  state_e                 dbg_state;

  modport master (
    output start, comp_in,
    input  ramp_reset, ramp_code, count, enable, busy, done, dbg_state
  );

  modport slave (
    input  start, comp_in,
    output ramp_reset, ramp_code, count, enable, busy, done, dbg_state
  );

endinterface

// File: rtl/ss_adc_conv_ctrl_comp_sync_edge.sv
// One comparator channel: 2-FF synchroniser followed by a registered rising-edge detector
// whose history is forced low while clear_i is high.
module comp_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic comp_i,
  input  logic clear_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, hist_q, edge_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= comp_i;
      sync2_q <= sync1_q;
      // With history held low, a level that is already high reads as an edge once released.
      if (clear_i) begin
        hist_q <= 1'b0;
        edge_q <= 1'b0;
      end else begin
        hist_q <= sync2_q;
        edge_q <= sync2_q & ~hist_q;
      end
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/ss_adc_conv_ctrl.sv
// Single-slope ADC conversion controller: sequences settle/ramp/drain, drives the ramp DAC
// and issues latency-aligned per-pixel capture strobes, saturating pixels that never trip.
module ss_adc_conv_ctrl import ss_adc_pkg::*; #(
  parameter int NUM_PIXELS    = 5,
  parameter int COUNT_WIDTH   = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  ss_adc_conv_ctrl_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] CODE_MAX = '1;
  localparam int PHASE_MAX = (SETTLE_CYCLES > LAT) ? SETTLE_CYCLES : LAT;
  localparam int PCW       = $clog2(PHASE_MAX + 1);

  state_e                 state_q, state_d;
  logic [PCW-1:0]         phase_q, phase_d;
  logic [COUNT_WIDTH-1:0] ramp_code_q, ramp_code_d;
  logic [COUNT_WIDTH-1:0] code_p1_q, code_p2_q, count_q, count_d;
  logic                   vld1_q, vld2_q, vld3_q;
  logic [NUM_PIXELS-1:0]  captured_q, captured_d;
  logic [NUM_PIXELS-1:0]  edge_vec, enable;
  logic                   sync_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      ramp_code_q <= '0;
      code_p1_q   <= '0;
      code_p2_q   <= '0;
      count_q     <= '0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      vld3_q      <= 1'b0;
      captured_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ramp_code_q <= ramp_code_d;
      code_p1_q   <= ramp_code_q;
      code_p2_q   <= code_p1_q;
      count_q     <= count_d;
      vld1_q      <= (state_q == RAMP);
      vld2_q      <= vld1_q;
      vld3_q      <= vld2_q;
      captured_q  <= captured_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ramp_code_d = ramp_code_q;
    case (state_q)
      IDLE: begin
        ramp_code_d = '0;
        if (bus.start) begin
          state_d = SETTLE;
          phase_d = '0;
        end
      end
      SETTLE: begin
        ramp_code_d = '0;
        if (phase_q == PCW'(SETTLE_CYCLES - 1)) begin
          state_d = RAMP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PCW'(1);
        end
      end
      RAMP: begin
        if (ramp_code_q == CODE_MAX) state_d = DRAIN;
        else ramp_code_d = ramp_code_q + COUNT_WIDTH'(1);
      end
      DRAIN: begin
        if (phase_q == PCW'(LAT - 1)) begin
          state_d = FINISH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PCW'(1);
        end
      end
      FINISH: begin
        state_d     = IDLE;
        ramp_code_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Comparator samples taken before the first ramp code reach the edge stage while
  // vld2_q is low, so this clear lines the edge path up with the code pipeline.
  assign sync_clear = ~vld2_q;

  for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
    comp_sync_edge u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .comp_i  (bus.comp_in[gi]),
      .clear_i (sync_clear),
      .edge_o  (edge_vec[gi])
    );
  end

  always_comb begin
    enable = ((edge_vec & {NUM_PIXELS{vld3_q}}) | {NUM_PIXELS{state_q == FINISH}}) & ~captured_q;
    captured_d = (state_q == SETTLE) ? '0 : (captured_q | enable);
    count_d = count_q;
    if (vld2_q) count_d = code_p2_q;
    else if (state_q == DRAIN && state_d == FINISH) count_d = CODE_MAX;
  end

  assign bus.ramp_reset = (state_q == IDLE) || (state_q == SETTLE);
  assign bus.ramp_code  = ramp_code_q;
  assign bus.count      = count_q;
  assign bus.enable     = enable;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FINISH);
  assign bus.dbg_state  = state_q;

endmodule
